// File: rtl/red_pkg.sv
// Shared constants and helpers for the RED nibble-sum reduction pipeline.
package red_pkg;

   localparam int unsigned RED_W_IN  = 16;
   localparam int unsigned RED_W_L1  = 5;
   localparam int unsigned RED_W_L2  = 6;
   localparam int unsigned RED_W_L3  = 7;
   localparam int unsigned RED_DEPTH = 3;

   // Sign-extend two nibbles by one bit and add; the 5-bit result cannot overflow.
   function automatic logic [RED_W_L1-1:0] red_pair(input logic [3:0] a, input logic [3:0] b);
      return {a[3], a} + {b[3], b};
   endfunction

endpackage

// File: rtl/red_pipe_reg.sv
// One pipeline stage register: valid bit plus payload, async clear, flush and enable.
module red_pipe_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         en,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Payload only loads with a valid operation, so bubbles do not toggle the data flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (en) begin
         valid_q <= valid_i;
         if (valid_i) begin
            data_q <= data_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/red_pipe_unit.sv
// Three-stage pipelined sum of the eight signed nibbles of two 16-bit operands,
// with valid/ready handshakes, flush and tag tracking.
module red_pipe_unit
   import red_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [15:0]         in_a,
   input  logic [15:0]         in_b,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [15:0]         out_s,
   output logic [TAG_W-1:0]    out_tag,
   output logic                busy
);

   localparam int unsigned S1_W = 4 * RED_W_L1 + TAG_W;
   localparam int unsigned S2_W = 2 * RED_W_L2 + TAG_W;
   localparam int unsigned S3_W = RED_W_L3 + TAG_W;

   logic [RED_DEPTH-1:0] v;
   logic [RED_DEPTH-1:0] adv;

   logic [S1_W-1:0] s1_d, s1_q;
   logic [S2_W-1:0] s2_d, s2_q;
   logic [S3_W-1:0] s3_d, s3_q;

   logic [RED_W_L1-1:0] p3, p2, p1, p0;
   logic [RED_W_L2-1:0] q1_d, q0_d, q1, q0;
   logic [RED_W_L3-1:0] r_d, r_q;
   logic [TAG_W-1:0]    t1, t2, t3;

   // A stage moves when it is empty or its successor moves; S3 moves on out_ready.
   always_comb begin
      adv[2] = out_ready || !v[2];
      adv[1] = !v[1] || adv[2];
      adv[0] = !v[0] || adv[1];
   end

   assign in_ready = adv[0] && !flush && !rst;

   assign s1_d = {red_pair(in_a[15:12], in_b[15:12]), red_pair(in_a[11:8], in_b[11:8]),
                  red_pair(in_a[7:4], in_b[7:4]), red_pair(in_a[3:0], in_b[3:0]), in_tag};

   assign {p3, p2, p1, p0, t1} = s1_q;
   assign q1_d = {p3[RED_W_L1-1], p3} + {p2[RED_W_L1-1], p2};
   assign q0_d = {p1[RED_W_L1-1], p1} + {p0[RED_W_L1-1], p0};
   assign s2_d = {q1_d, q0_d, t1};

   assign {q1, q0, t2} = s2_q;
   assign r_d  = {q1[RED_W_L2-1], q1} + {q0[RED_W_L2-1], q0};
   assign s3_d = {r_d, t2};

   assign {r_q, t3} = s3_q;

   red_pipe_reg #(.W(S1_W)) u_stage1 (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .en      (adv[0]),
      .valid_i (in_valid),
      .data_i  (s1_d),
      .valid_o (v[0]),
      .data_o  (s1_q)
   );

   red_pipe_reg #(.W(S2_W)) u_stage2 (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .en      (adv[1]),
      .valid_i (v[0]),
      .data_i  (s2_d),
      .valid_o (v[1]),
      .data_o  (s2_q)
   );

   red_pipe_reg #(.W(S3_W)) u_stage3 (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .en      (adv[2]),
      .valid_i (v[1]),
      .data_i  (s3_d),
      .valid_o (v[2]),
      .data_o  (s3_q)
   );

   assign out_valid = v[2];
   assign out_s     = {{(RED_W_IN - RED_W_L3){r_q[RED_W_L3-1]}}, r_q};
   assign out_tag   = t3;
   assign busy      = |v;

endmodule

// File: tb/tb_red_pipe_unit.sv
// Scoreboard bench for red_pipe_unit: directed corner cases plus randomized traffic.
module tb_red_pipe_unit;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_a = '0;
   logic [15:0]      in_b = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [15:0]      out_s;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   typedef struct packed {
      logic [15:0]      s;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   red_pipe_unit #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: plain integer sum of the eight signed nibbles.
   function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
      int sum;
      int na;
      int nb;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         na = int'(a[4*i +: 4]);
         nb = int'(b[4*i +: 4]);
         if (na > 7) na -= 16;
         if (nb > 7) nb -= 16;
         sum += na + nb;
      end
      return 16'(sum);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive after the falling edge, log acceptance, model flush.
   task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [TAG_W-1:0] t, input logic ordy, input logic fl,
                       output logic acc);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_tag    = t;
      out_ready = ordy;
      flush     = fl;
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
         e.s   = ref_red(a, b);
         e.tag = t;
         sb.push_back(e);
      end
      #2;
      if (flush) sb.delete();
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, 16'h0, 16'h0, '0, ordy, 1'b0, acc);
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks stall stability.
   initial begin
      logic             hold;
      logic [15:0]      h_s;
      logic [TAG_W-1:0] h_tag;
      exp_t             e;
      hold = 1'b0;
      h_s = '0;
      h_tag = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_s", 32'(out_s), 32'(h_s));
               chk("hold_tag", 32'(out_tag), 32'(h_tag));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_out: got s=%h tag=%0h want none", out_s, out_tag);
               end else begin
                  e = sb.pop_front();
                  chk("out_s", 32'(out_s), 32'(e.s));
                  chk("out_tag", 32'(out_tag), 32'(e.tag));
               end
            end
            hold  = out_valid && !out_ready && !flush;
            h_s   = out_s;
            h_tag = out_tag;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic        acc;
      logic [14:0] vis;
      logic [15:0] ra;
      logic [15:0] rb;

      // Reset state.
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_s", 32'(out_s), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // Positive extreme and latency: presented in cycle C, visible in cycle C+3.
      step(1'b1, 16'h7777, 16'h7777, 4'd5, 1'b1, 1'b0, acc);
      chk("lat_acc", 32'(acc), 32'd1);
      idle(1'b1);
      chk("lat_c1", 32'(out_valid), 32'd0);
      idle(1'b1);
      chk("lat_c2", 32'(out_valid), 32'd0);
      idle(1'b1);
      chk("lat_c3", 32'(out_valid), 32'd1);
      chk("lat_s", 32'(out_s), 32'h0038);
      idle(1'b1);

      // Negative extreme and mixed signs.
      step(1'b1, 16'h8888, 16'h8888, 4'd6, 1'b1, 1'b0, acc);
      step(1'b1, 16'hFFFF, 16'h0001, 4'd7, 1'b1, 1'b0, acc);
      repeat (4) idle(1'b1);

      // Ten back-to-back: results on ten consecutive cycles.
      vis = '0;
      for (int i = 0; i < 15; i++) begin
         if (i < 10) step(1'b1, 16'($urandom), 16'($urandom), 4'(i), 1'b1, 1'b0, acc);
         else idle(1'b1);
         vis[i] = out_valid;
      end
      chk("b2b_pattern", 32'(vis), 32'h1FF8);

      // Stall: three accepted, fourth blocked, first result held.
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 16'h1234, 16'h0000, 4'(i), 1'b0, 1'b0, acc);
         chk("stall_acc", 32'(acc), (i < 4) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'h1234, 16'h0000, 4'd4, 1'b0, 1'b0, acc);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_s", 32'(out_s), 32'h000A);
         chk("stall_tag", 32'(out_tag), 32'd1);
      end
      acc = 1'b0;
      for (int i = 0; i < 5 && !acc; i++) begin
         step(1'b1, 16'h1234, 16'h0000, 4'd4, 1'b1, 1'b0, acc);
      end
      chk("stall_release_acc", 32'(acc), 32'd1);
      repeat (6) idle(1'b1);

      // Flush with three in flight; offered operation during flush is refused.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'($urandom), 16'($urandom), 4'(8 + i), 1'b1, 1'b0, acc);
      end
      step(1'b1, 16'h1111, 16'h1111, 4'd11, 1'b1, 1'b1, acc);
      chk("flush_acc", 32'(acc), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      idle(1'b1);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_busy", 32'(busy), 32'd0);
      step(1'b1, 16'h2345, 16'hF0F0, 4'd12, 1'b1, 1'b0, acc);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("post_flush_valid", 32'(out_valid), 32'd1);
      repeat (2) idle(1'b1);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'($urandom), 16'($urandom), 4'(i), 1'b1, 1'b0, acc);
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      sb.delete();
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      chk("arst_out_s", 32'(out_s), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_rel_in_ready", 32'(in_ready), 32'd1);
      repeat (6) idle(1'b1);
      chk("arst_no_stale", 32'(busy), 32'd0);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 600; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         step($urandom_range(0, 9) < 7, ra, rb, 4'($urandom), $urandom_range(0, 9) < 6,
              $urandom_range(0, 59) == 0, acc);
      end
      repeat (10) idle(1'b1);
      chk("drain_empty", 32'(sb.size()), 32'd0);
      chk("drain_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
